// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared constants for the RAM-backed FIFO controller
// Holds the staging buffer depth and the RAM port command encodings.
// Optional feature macro used by the controller: RAM_FIFO_BYPASS_EN.
package ram_fifo_pkg;

    localparam int STG_DEPTH = 2;

    typedef struct packed {
        logic en;
        logic wr;
    } ram_cmd_t;

    // The attached RAM uses an inverted write strobe: wr=0 writes, wr=1 reads.
    localparam ram_cmd_t RAM_CMD_WR = '{en: 1'b1, wr: 1'b0};
    localparam ram_cmd_t RAM_CMD_RD = '{en: 1'b1, wr: 1'b1};

endpackage

// File: rtl/ram_fifo_stage.sv
// rtl/ram_fifo_stage.sv - 2-entry in-order staging buffer in front of the FIFO output
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   push_i, push_data_i     write one word into the tail
//   pop_i                   remove the head word
//   cnt_o                   number of words held (0..2)
//   head_o                  head word, zero when empty
module ram_fifo_stage
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            cnt_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam logic [1:0] FULL = 2'(STG_DEPTH);

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]            cnt_q, cnt_d;

    // Entry 0 is always the head; vacated slots are cleared so the head
    // output reads zero whenever the buffer is empty.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (pop_i && (cnt_q != 2'd0)) begin
            ent0_d = ent1_q;
            ent1_d = '0;
            cnt_d  = cnt_q - 2'd1;
        end
        // Tail slot is chosen from the occupancy left after any pop.
        if (push_i && (cnt_d < FULL)) begin
            if (cnt_d == 2'd0) begin
                ent0_d = push_data_i;
            end else begin
                ent1_d = push_data_i;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = ent0_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - valid/ready FIFO controller using an external dual-port RAM
// Port A of the RAM is write-only, port B read-only with 1-cycle registered
// read latency; a 2-entry staging buffer keeps throughput at one word/cycle.
// Optional feature macro: RAM_FIFO_BYPASS_EN (push straight into staging when
// nothing older is in the RAM path).
// Ports:
//   clock, reset_n                  clock and asynchronous active-low reset
//   in_valid, in_ready, in_data     push handshake
//   out_valid, out_ready, out_data  pop handshake, out_data zero when empty
//   count                           words held: RAM + in-flight read + staging
//   ram_en_a, ram_wr_a, ram_addr_a, ram_wdata_a   RAM write port
//   ram_en_b, ram_wr_b, ram_addr_b, ram_rdata_b   RAM read port
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 3)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count,
    output logic                  ram_en_a,
    output logic                  ram_wr_a,
    output logic [AW-1:0]         ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_wdata_a,
    output logic                  ram_en_b,
    output logic                  ram_wr_b,
    output logic [AW-1:0]         ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_rdata_b
);

    localparam logic [AW:0] RAM_FULL = (AW + 1)'(DEPTH);
    localparam logic [2:0]  STG_MAX  = 3'(STG_DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          pend_q, pend_d;

    logic [1:0]            stg_cnt;
    logic [DATA_WIDTH-1:0] stg_head;
    logic                  stg_push;
    logic [DATA_WIDTH-1:0] stg_push_data;

    logic       push_fire;
    logic       pop_fire;
    logic       ram_write;
    logic       issue;
    logic       bypass;
    logic [2:0] stg_occ;

    // in_ready looks only at registered state, never at out_ready.
    assign in_ready  = reset_n && (ram_cnt_q < RAM_FULL);
    assign push_fire = in_valid && in_ready;
    assign out_valid = (stg_cnt != 2'd0);
    assign pop_fire  = out_valid && out_ready;
    assign out_data  = stg_head;

    // Staging slots committed after this edge: held + in-flight - popped.
    assign stg_occ = {1'b0, stg_cnt} + {2'b00, pend_q} - {2'b00, pop_fire};

    // ram_cnt excludes the word written this cycle, so the read address can
    // never collide with the write address on the same edge.
    assign issue = (ram_cnt_q != '0) && (stg_occ < STG_MAX);

`ifdef RAM_FIFO_BYPASS_EN
    // Only safe when no older word sits in the RAM or the read pipeline.
    assign bypass = push_fire && (ram_cnt_q == '0) && !pend_q && (stg_occ < STG_MAX);
`else
    assign bypass = 1'b0;
`endif

    assign ram_write = push_fire && !bypass;

    // A bypassed push and a capture are mutually exclusive (bypass needs pend=0).
    assign stg_push      = pend_q || bypass;
    assign stg_push_data = pend_q ? ram_rdata_b : in_data;

    assign ram_en_a    = ram_write && RAM_CMD_WR.en;
    assign ram_wr_a    = RAM_CMD_WR.wr;
    assign ram_addr_a  = wptr_q;
    assign ram_wdata_a = ram_write ? in_data : '0;
    assign ram_en_b    = issue && RAM_CMD_RD.en;
    assign ram_wr_b    = RAM_CMD_RD.wr;
    assign ram_addr_b  = rptr_q;

    assign count = CW'(ram_cnt_q) + CW'(pend_q) + CW'(stg_cnt);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        pend_d    = issue;
        if (ram_write) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (issue) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (ram_write && !issue) begin
            ram_cnt_d = ram_cnt_q + (AW + 1)'(1);
        end else if (!ram_write && issue) begin
            ram_cnt_d = ram_cnt_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            pend_q    <= pend_d;
        end
    end

    ram_fifo_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (stg_push),
        .push_data_i (stg_push_data),
        .pop_i       (pop_fire),
        .cnt_o       (stg_cnt),
        .head_o      (stg_head)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a behavioural dual-port RAM
module tb_ram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 3);
`ifdef RAM_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          ram_en_a, ram_wr_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_wdata_a;
    logic          ram_en_b, ram_wr_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_rdata_b;

    always #5 clock = ~clock;

    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clock) begin
        if (ram_en_a && !ram_wr_a) ram_mem[ram_addr_a] <= ram_wdata_a;
        if (ram_en_b && ram_wr_b) ram_rdata_b <= ram_mem[ram_addr_b];
        else                      ram_rdata_b <= '0;
    end

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .ram_en_a    (ram_en_a),
        .ram_wr_a    (ram_wr_a),
        .ram_addr_a  (ram_addr_a),
        .ram_wdata_a (ram_wdata_a),
        .ram_en_b    (ram_en_b),
        .ram_wr_b    (ram_wr_b),
        .ram_addr_b  (ram_addr_b),
        .ram_rdata_b (ram_rdata_b)
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_cnt;
        logic          e_ena;
        logic [AW-1:0] e_aa;
        logic          e_enb;
        logic [AW-1:0] e_ab;
    } vec_t;

    vec_t vt [12];

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    int cnt_err  = 0;
    int max_cnt  = 0;
    logic [DW-1:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic ordy,
                                input logic ir, input logic ov, input logic [DW-1:0] od,
                                input logic [CW-1:0] cnt, input logic ena, input logic [AW-1:0] aa,
                                input logic enb, input logic [AW-1:0] ab);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.e_ir = ir; v.e_ov = ov; v.e_od = od;
        v.e_cnt = cnt; v.e_ena = ena; v.e_aa = aa; v.e_enb = enb; v.e_ab = ab;
        return v;
    endfunction

    // Called just after a falling edge with inputs already driven; scores the
    // cycle's handshakes, then advances to the next falling edge.
    task automatic step();
        #1;
        if (int'(count) != sb.size()) cnt_err++;
        if (int'(count) > DEPTH + 2) cnt_err++;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (in_valid && in_ready) sb.push_back(in_data);
        if (out_valid && out_ready) begin
            n_pops++;
            if (sb.size() == 0) check("pop_unexpected", 64'd1, 64'd0);
            else                check("pop_data", {32'd0, out_data}, {32'd0, sb.pop_front()});
        end
        @(negedge clock);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pops0;
        int first_pop;

`ifdef RAM_FIFO_BYPASS_EN
        vt[0]  = mk(1'b1, 32'hA5A50001, 1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[1]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA5A50001, 5'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[2]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A50001, 5'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[3]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[4]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[5]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[6]  = mk(1'b1, 32'hB0000001, 1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[7]  = mk(1'b1, 32'hB0000002, 1'b1, 1'b1, 1'b1, 32'hB0000001, 5'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[8]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hB0000002, 5'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[9]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[10] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[11] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
`else
        vt[0]  = mk(1'b1, 32'hA5A50001, 1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b1, 4'd0, 1'b0, 4'd0);
        vt[1]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd1, 1'b0, 4'd0, 1'b1, 4'd0);
        vt[2]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[3]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA5A50001, 5'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[4]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A50001, 5'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[5]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[6]  = mk(1'b1, 32'hB0000001, 1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b1, 4'd1, 1'b0, 4'd0);
        vt[7]  = mk(1'b1, 32'hB0000002, 1'b1, 1'b1, 1'b0, 32'h0,        5'd1, 1'b1, 4'd2, 1'b1, 4'd1);
        vt[8]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd2, 1'b0, 4'd0, 1'b1, 4'd2);
        vt[9]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hB0000001, 5'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[10] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hB0000002, 5'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        vt[11] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 4'd0, 1'b0, 4'd0);
`endif

        // Reset then idle
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clock);
        #1;
        check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("idle_in_ready",  {63'd0, in_ready},  64'd1);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check("idle_out_data",  {32'd0, out_data},  64'd0);
        check("idle_count",     {59'd0, count},     64'd0);
        check("idle_ram_en_a",  {63'd0, ram_en_a},  64'd0);
        check("idle_ram_en_b",  {63'd0, ram_en_b},  64'd0);
        @(negedge clock);

        // Cycle-by-cycle vectors: single word, then two back-to-back words
        for (int i = 0; i < 12; i++) begin
            in_valid = vt[i].iv; in_data = vt[i].id; out_ready = vt[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i),  {63'd0, in_ready},  {63'd0, vt[i].e_ir});
            check($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].e_ov});
            check($sformatf("vec%0d_out_data", i),  {32'd0, out_data},  {32'd0, vt[i].e_od});
            check($sformatf("vec%0d_count", i),     {59'd0, count},     {59'd0, vt[i].e_cnt});
            check($sformatf("vec%0d_ram_en_a", i),  {63'd0, ram_en_a},  {63'd0, vt[i].e_ena});
            check($sformatf("vec%0d_ram_en_b", i),  {63'd0, ram_en_b},  {63'd0, vt[i].e_enb});
            if (vt[i].e_ena) begin
                check($sformatf("vec%0d_ram_addr_a", i),  {60'd0, ram_addr_a}, {60'd0, vt[i].e_aa});
                check($sformatf("vec%0d_ram_wdata_a", i), {32'd0, ram_wdata_a}, {32'd0, vt[i].id});
            end
            if (vt[i].e_enb) check($sformatf("vec%0d_ram_addr_b", i), {60'd0, ram_addr_b}, {60'd0, vt[i].e_ab});
            step();
        end
        in_valid = 1'b0;

        // Fill to full with out_ready low: 20 attempts, 18 accepted
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = DW'(sb.size());
            step();
        end
        in_valid = 1'b0;
        #1;
        check("full_count",    {59'd0, count},    64'd18);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_accepted", 64'(sb.size()),    64'd18);
        out_ready = 1'b1;
        #1;
        check("full_pop_issue", {63'd0, ram_en_b}, 64'd1);
        step();
        #1;
        check("full_in_ready_reraised", {63'd0, in_ready}, 64'd1);
        for (int k = 0; k < 100 && sb.size() != 0; k++) step();
        check("full_drained", 64'(sb.size()), 64'd0);
        #1;
        check("full_count_zero", {59'd0, count}, 64'd0);
        @(negedge clock);

        // Streaming: 1000 words with valid/ready held high
        first_pop = -1;
        pops0 = n_pops;
        out_ready = 1'b1;
        for (int c = 0; c < 1000 + LAT; c++) begin
            in_valid = (c < 1000);
            in_data  = 32'h5000_0000 + DW'(c);
            if (c < 1000) begin
                #1;
                if (!in_ready) check("stream_in_ready", 64'd0, 64'd1);
            end
            step();
            if (first_pop < 0 && n_pops != pops0) first_pop = c;
        end
        in_valid = 1'b0;
        check("stream_latency", 64'(first_pop), 64'(LAT));
        check("stream_pops",    64'(n_pops - pops0), 64'd1000);
        check("stream_empty",   64'(sb.size()), 64'd0);

        // Random backpressure
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            in_data   = $urandom;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) step();
        check("rand_drained", 64'(sb.size()), 64'd0);
        check("rand_max_count_bound", 64'(max_cnt <= DEPTH + 2), 64'd1);
        check("count_model_all_cycles", 64'(cnt_err), 64'd0);

        // Mid-operation reset with count=7 and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 32'hC000_0000 + DW'(i);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("mid_count8", {59'd0, count}, 64'd8);
        out_ready = 1'b1;
        #1;
        check("mid_issue", {63'd0, ram_en_b}, 64'd1);
        step();
        out_ready = 1'b0;
        #1;
        check("mid_count7", {59'd0, count}, 64'd7);
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  {63'd0, in_ready},    64'd0);
        check("mid_rst_out_valid", {63'd0, out_valid},   64'd0);
        check("mid_rst_out_data",  {32'd0, out_data},    64'd0);
        check("mid_rst_count",     {59'd0, count},       64'd0);
        check("mid_rst_ram_en_a",  {63'd0, ram_en_a},    64'd0);
        check("mid_rst_ram_en_b",  {63'd0, ram_en_b},    64'd0);
        check("mid_rst_addr_a",    {60'd0, ram_addr_a},  64'd0);
        check("mid_rst_addr_b",    {60'd0, ram_addr_b},  64'd0);
        check("mid_rst_wdata_a",   {32'd0, ram_wdata_a}, 64'd0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_count",    {59'd0, count},    64'd0);
        pops0 = n_pops;
        in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && n_pops == pops0; k++) step();
        check("post_rst_first_pop", 64'(n_pops - pops0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
